axil_ram: RTL and testbench
===========================

# axil_ram

Parametrised AXI4-Lite slave RAM with fully decoupled write-address and write-data channels, per-byte strobes, and a full-throughput single-cycle-latency read path. It hangs off the PCIe-to-AXI bridge's AXI-Lite master port as general-purpose scratch/mailbox memory. It succeeds the fixed 32-bit/256-word minimal slave: it adds configurable width and depth, honours WSTRB, applies real backpressure, and optionally flags out-of-range accesses.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, data width; 32 or 64 only
- DEPTH_LOG2, 8, log2 of word count; memory holds 2^DEPTH_LOG2 words of DATA_WIDTH
- Derived (not overridable): STRB_WIDTH = DATA_WIDTH/8; OFS = log2(STRB_WIDTH)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- s_axi_awaddr / awvalid / awready  in/in/out  ADDR_WIDTH/1/1  write address channel
- s_axi_wdata / wstrb / wvalid / wready  in/in/in/out  DATA_WIDTH/STRB_WIDTH/1/1  write data channel
- s_axi_bresp / bvalid / bready  out/out/in  2/1/1  write response channel
- s_axi_araddr / arvalid / arready  in/in/out  ADDR_WIDTH/1/1  read address channel
- s_axi_rdata / rresp / rvalid / rready  out/out/out/in  DATA_WIDTH/2/1/1  read data channel

## Operation
- Word index = addr[OFS+DEPTH_LOG2-1:OFS]. Address bits [OFS-1:0] are ignored.
- Write side: one-entry holding registers, aw_hold (address plus flag) and w_hold (data, strobe, flag).
  - awready = !aw_full; wready = !w_full. Both are driven from flops.
  - AW and W are accepted independently, in either order, with any gap between them.
- Commit: when aw_full && w_full && (!bvalid || bready):
  - write each byte lane whose strobe bit is set; leave lanes with strobe 0 untouched;
  - clear both full flags;
  - set bvalid = 1, bresp = 2'b00.
- bvalid clears on bvalid && bready, unless a commit happens on the same edge (then it stays 1).
- Read side:
  - arready = !rvalid || rready. This is the only combinational path from an input (rready) to an output.
  - AR handshake: rdata <= mem[index], rresp <= 2'b00, rvalid <= 1.
  - rvalid clears on rvalid && rready when no new AR handshake occurs on the same edge.
  - rdata is held stable while rvalid && !rready.
- Read and write collide (AR handshake and commit to the same index on the same edge): the read returns the old data.
- Memory contents are initialised to zero at configuration and are not cleared by rst_n.

## Timing
- Reset values: awready = 1, wready = 1, arready = 1, bvalid = 0, bresp = 00, rvalid = 0, rresp = 00, rdata = 0.
- Write, AW and W on the same edge N:
  - commit at edge N+1; bvalid high after N+1;
  - awready/wready low for one cycle after N, high again after N+1.
  - Sustained rate: one write per 2 cycles with bready tied high.
- Write, AW at N and W at M > N: commit at edge M+1; awready stays low until after the commit.
- bready held low: holds stay full, the next commit stalls, and AW/W backpressure after one buffered beat each.
- Read: data is valid the cycle after the AR handshake. With rready high, one read per cycle sustained.
- Reset mid-operation: on the reset edge, holds, pending B and pending R are dropped. No memory write occurs on or after the reset edge until new handshakes arrive.

## Configuration
- Macro: AXIL_RAM_RANGE_CHK_EN.
- Defined: any set address bit above OFS+DEPTH_LOG2-1 marks the access as out of range.
  - Out-of-range write: commit discards the data (memory unchanged), bresp = 2'b10 (SLVERR).
  - Out-of-range read: rdata = 0, rresp = 2'b10.
  - Handshake timing is unchanged.
- Undefined: upper address bits are ignored, addresses alias modulo the memory size, and every response is OKAY.

## Test plan
- Reset, then write 0xDEADBEEF to 0x10 with wstrb 0xF, AW and W on the same cycle, then read 0x10 -> bresp 00; rdata 0xDEADBEEF one cycle after AR; reset values checked beforehand.
- W (0x11223344, strb 0xF, addr later 0x20) presented 3 cycles before AW; then wstrb 0x5, data 0xAABBCCDD to 0x20 -> wready low after W is buffered; commit 1 cycle after AW; final read of 0x20 = 0x11BB33DD.
- 16 back-to-back reads of 0x00..0x3C with rready high -> arready stays 1, 16 consecutive rvalid beats, in order. Repeat with rready toggling every cycle -> no beat lost or duplicated.
- bready low for 10 cycles while 3 writes are offered -> exactly one bvalid pending and one beat buffered per channel, no memory change beyond the first write; release bready -> the remaining writes complete in order.
- With AXIL_RAM_RANGE_CHK_EN defined (DEPTH_LOG2 = 8, 32-bit data), write 0x55 to 0x400 then read 0x400 and 0x000 -> bresp 10, rresp 10 with rdata 0, address 0x000 unchanged. Without the macro -> OKAY responses and 0x000 reads 0x55.
- Assert rst_n for one cycle between the AW and W beats of a write to 0x8 -> no write to 0x8, no bvalid, ready signals return to 1.

Source files
------------

// File: rtl/axil_ram.sv
// axil_ram: AXI4-Lite slave RAM for the PCIe bridge's scratch/mailbox space.
// AW and W are buffered independently in one-entry holding registers and
// committed together; reads return one cycle after the AR handshake.
// Optional feature: define AXIL_RAM_RANGE_CHK_EN to reject out-of-range
// accesses with SLVERR instead of aliasing them into the memory.
module axil_ram #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [1:0]              s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int OFS        = $clog2(STRB_WIDTH);
   localparam int DEPTH      = 2 ** DEPTH_LOG2;

   // Contents start at zero and deliberately survive rst_n.
   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

   logic                  aw_full;
   logic [DEPTH_LOG2-1:0] aw_idx;
   logic                  aw_oor;
   logic                  w_full;
   logic [DATA_WIDTH-1:0] w_data;
   logic [STRB_WIDTH-1:0] w_strb;

   logic                  aw_hs;
   logic                  w_hs;
   logic                  ar_hs;
   logic                  commit;
   logic                  aw_oor_in;
   logic                  ar_oor_in;
   logic [DEPTH_LOG2-1:0] ar_idx;
   logic                  unused_addr;

   assign aw_hs  = s_axi_awvalid && !aw_full;
   assign w_hs   = s_axi_wvalid && !w_full;
   assign commit = aw_full && w_full && (!s_axi_bvalid || s_axi_bready);
   assign ar_hs  = s_axi_arvalid && s_axi_arready;
   assign ar_idx = s_axi_araddr[OFS+DEPTH_LOG2-1:OFS];

   assign s_axi_awready = !aw_full;
   assign s_axi_wready  = !w_full;
   assign s_axi_arready = !s_axi_rvalid || s_axi_rready;

`ifdef AXIL_RAM_RANGE_CHK_EN
   assign aw_oor_in = |s_axi_awaddr[ADDR_WIDTH-1:OFS+DEPTH_LOG2];
   assign ar_oor_in = |s_axi_araddr[ADDR_WIDTH-1:OFS+DEPTH_LOG2];
`else
   assign aw_oor_in = 1'b0;
   assign ar_oor_in = 1'b0;
`endif

   // Byte-offset bits (and upper bits when aliasing) are intentionally dropped.
   assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};

   // Write-side holding registers and the B channel; a commit frees both holds.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         aw_full      <= 1'b0;
         aw_idx       <= '0;
         aw_oor       <= 1'b0;
         w_full       <= 1'b0;
         w_data       <= '0;
         w_strb       <= '0;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= 2'b00;
      end else begin
         if (aw_hs) begin
            aw_full <= 1'b1;
            aw_idx  <= s_axi_awaddr[OFS+DEPTH_LOG2-1:OFS];
            aw_oor  <= aw_oor_in;
         end else if (commit) begin
            aw_full <= 1'b0;
         end

         if (w_hs) begin
            w_full <= 1'b1;
            w_data <= s_axi_wdata;
            w_strb <= s_axi_wstrb;
         end else if (commit) begin
            w_full <= 1'b0;
         end

         if (commit) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= aw_oor ? 2'b10 : 2'b00;
         end else if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
         end
      end
   end

   // Byte-lane memory update on commit; suppressed on the reset edge.
   always_ff @(posedge clk) begin
      if (rst_n && commit && !aw_oor) begin
         for (int i = 0; i < STRB_WIDTH; i++) begin
            if (w_strb[i]) begin
               mem[aw_idx][i*8 +: 8] <= w_data[i*8 +: 8];
            end
         end
      end
   end

   // Read data register: loads on AR handshake (old data on a same-edge commit),
   // holds while stalled, and drops valid once consumed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_axi_rvalid <= 1'b0;
         s_axi_rresp  <= 2'b00;
         s_axi_rdata  <= '0;
      end else if (ar_hs) begin
         s_axi_rvalid <= 1'b1;
         if (ar_oor_in) begin
            s_axi_rdata <= '0;
            s_axi_rresp <= 2'b10;
         end else begin
            s_axi_rdata <= mem[ar_idx];
            s_axi_rresp <= 2'b00;
         end
      end else if (s_axi_rready) begin
         s_axi_rvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axil_ram.sv
// tb_axil_ram: directed and randomized checks of axil_ram against a
// word-array reference model. Honours AXIL_RAM_RANGE_CHK_EN in the model.
module tb_axil_ram;

   localparam int TMO = 50;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] s_axi_awaddr;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;
   logic [31:0] s_axi_araddr;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready;

   int checks = 0;
   int errors = 0;

   logic [31:0] modelMem [256];

   axil_ram #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
      .s_axi_rready(s_axi_rready)
   );

   always #5 clk = ~clk;

   // Hard stop in case a wait escapes its bound.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference model: 256 words, byte address / 4 modulo 256.
   function automatic bit modelOor(input logic [31:0] addr);
`ifdef AXIL_RAM_RANGE_CHK_EN
      return addr >= 32'h400;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int modelIdx(input logic [31:0] addr);
      return int'((addr / 4) % 256);
   endfunction

   function automatic logic [31:0] modelRead(input logic [31:0] addr);
      return modelOor(addr) ? 32'h0 : modelMem[modelIdx(addr)];
   endfunction

   function automatic logic [1:0] modelResp(input logic [31:0] addr);
      return modelOor(addr) ? 2'b10 : 2'b00;
   endfunction

   task automatic modelWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      if (!modelOor(addr)) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) modelMem[modelIdx(addr)][8*b +: 8] = data[8*b +: 8];
         end
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Full write transaction with independent AW/W delays and a delayed bready.
   task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int awDelay, input int wDelay, input int bDelay);
      bit awGot;
      bit wGot;
      bit bGot;
      logic [1:0] resp;
      awGot = 1'b0;
      wGot = 1'b0;
      bGot = 1'b0;
      s_axi_bready = 1'b0;
      fork
         begin
            repeat (awDelay) nextCycle();
            s_axi_awaddr = addr;
            s_axi_awvalid = 1'b1;
            for (int c = 0; c < TMO && !awGot; c++) begin
               @(negedge clk);
               awGot = s_axi_awready;
               nextCycle();
            end
            s_axi_awvalid = 1'b0;
         end
         begin
            repeat (wDelay) nextCycle();
            s_axi_wdata = data;
            s_axi_wstrb = strb;
            s_axi_wvalid = 1'b1;
            for (int c = 0; c < TMO && !wGot; c++) begin
               @(negedge clk);
               wGot = s_axi_wready;
               nextCycle();
            end
            s_axi_wvalid = 1'b0;
         end
      join
      if (!awGot || !wGot) checkOutput("write_handshake_timeout", 0, 1);
      for (int c = 0; c < TMO && !bGot; c++) begin
         @(negedge clk);
         bGot = s_axi_bvalid;
         nextCycle();
      end
      if (!bGot) begin
         checkOutput("bvalid_timeout", 0, 1);
      end else begin
         repeat (bDelay) nextCycle();
         s_axi_bready = 1'b1;
         @(negedge clk);
         resp = s_axi_bresp;
         nextCycle();
         s_axi_bready = 1'b0;
         checkOutput("bresp", resp, modelResp(addr));
         checkOutput("bvalid_clear", s_axi_bvalid, 0);
      end
      modelWrite(addr, data, strb);
   endtask

   // Full read transaction; data must be valid the cycle after AR and stay put while stalled.
   task automatic axiRead(input logic [31:0] addr, input int rDelay, output logic [31:0] data);
      bit got;
      logic [1:0] resp;
      logic [31:0] first;
      got = 1'b0;
      data = '0;
      s_axi_araddr = addr;
      s_axi_arvalid = 1'b1;
      s_axi_rready = 1'b0;
      for (int c = 0; c < TMO && !got; c++) begin
         @(negedge clk);
         got = s_axi_arready;
         nextCycle();
      end
      s_axi_arvalid = 1'b0;
      if (!got) begin
         checkOutput("ar_timeout", 0, 1);
      end else begin
         checkOutput("rvalid_after_ar", s_axi_rvalid, 1);
         first = s_axi_rdata;
         repeat (rDelay) nextCycle();
         if (rDelay > 0) checkOutput("rdata_hold", s_axi_rdata, first);
         s_axi_rready = 1'b1;
         @(negedge clk);
         data = s_axi_rdata;
         resp = s_axi_rresp;
         nextCycle();
         s_axi_rready = 1'b0;
         checkOutput("rdata", data, modelRead(addr));
         checkOutput("rresp", resp, modelResp(addr));
      end
   endtask

   // Random mix of reads and writes, occasionally with upper address bits set.
   task automatic applyStimulus(input int nOps);
      logic [31:0] addr;
      logic [31:0] rd;
      for (int k = 0; k < nOps; k++) begin
         addr = {22'd0, 8'($urandom), 2'($urandom)};
         if ($urandom_range(0, 7) == 0) addr[31:10] = 22'($urandom) | 22'd1;
         if ($urandom_range(0, 1) == 1)
            axiWrite(addr, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 2));
         else
            axiRead(addr, $urandom_range(0, 2), rd);
      end
   endtask

   task automatic testSameCycleWrite();
      s_axi_awaddr = 32'h10;
      s_axi_awvalid = 1'b1;
      s_axi_wdata = 32'hDEADBEEF;
      s_axi_wstrb = 4'hF;
      s_axi_wvalid = 1'b1;
      s_axi_bready = 1'b0;
      nextCycle();
      s_axi_awvalid = 1'b0;
      s_axi_wvalid = 1'b0;
      checkOutput("t1_awready_low", s_axi_awready, 0);
      checkOutput("t1_wready_low", s_axi_wready, 0);
      checkOutput("t1_bvalid_not_yet", s_axi_bvalid, 0);
      nextCycle();
      checkOutput("t1_bvalid", s_axi_bvalid, 1);
      checkOutput("t1_bresp", s_axi_bresp, 2'b00);
      checkOutput("t1_awready_back", s_axi_awready, 1);
      checkOutput("t1_wready_back", s_axi_wready, 1);
      s_axi_bready = 1'b1;
      nextCycle();
      s_axi_bready = 1'b0;
      checkOutput("t1_bvalid_clear", s_axi_bvalid, 0);
      modelWrite(32'h10, 32'hDEADBEEF, 4'hF);
      s_axi_araddr = 32'h10;
      s_axi_arvalid = 1'b1;
      @(negedge clk);
      checkOutput("t1_arready", s_axi_arready, 1);
      nextCycle();
      s_axi_arvalid = 1'b0;
      checkOutput("t1_rvalid", s_axi_rvalid, 1);
      checkOutput("t1_rdata", s_axi_rdata, 32'hDEADBEEF);
      checkOutput("t1_rresp", s_axi_rresp, 2'b00);
      s_axi_rready = 1'b1;
      nextCycle();
      s_axi_rready = 1'b0;
      checkOutput("t1_rvalid_clear", s_axi_rvalid, 0);
   endtask

   task automatic testWriteDataFirst();
      logic [31:0] rd;
      s_axi_wdata = 32'h11223344;
      s_axi_wstrb = 4'hF;
      s_axi_wvalid = 1'b1;
      nextCycle();
      s_axi_wvalid = 1'b0;
      checkOutput("t2_wready_low", s_axi_wready, 0);
      repeat (2) nextCycle();
      checkOutput("t2_no_early_b", s_axi_bvalid, 0);
      s_axi_awaddr = 32'h20;
      s_axi_awvalid = 1'b1;
      nextCycle();
      s_axi_awvalid = 1'b0;
      checkOutput("t2_bvalid_after_aw", s_axi_bvalid, 0);
      nextCycle();
      checkOutput("t2_bvalid_commit", s_axi_bvalid, 1);
      s_axi_bready = 1'b1;
      nextCycle();
      s_axi_bready = 1'b0;
      modelWrite(32'h20, 32'h11223344, 4'hF);
      axiWrite(32'h20, 32'hAABBCCDD, 4'h5, 0, 0, 0);
      axiRead(32'h20, 1, rd);
      checkOutput("t2_merged", rd, 32'h11BB33DD);
   endtask

   task automatic testBurstReads();
      s_axi_rready = 1'b1;
      for (int i = 0; i <= 16; i++) begin
         if (i > 0) begin
            checkOutput("burst_rvalid", s_axi_rvalid, 1);
            checkOutput("burst_rdata", s_axi_rdata, modelMem[i-1]);
         end
         if (i < 16) begin
            s_axi_araddr = 32'(i * 4);
            s_axi_arvalid = 1'b1;
            @(negedge clk);
            checkOutput("burst_arready", s_axi_arready, 1);
            nextCycle();
         end else begin
            s_axi_arvalid = 1'b0;
         end
      end
      nextCycle();
      s_axi_rready = 1'b0;
      checkOutput("burst_drained", s_axi_rvalid, 0);
   endtask

   task automatic testToggleReads();
      logic [31:0] beats [$];
      bit got;
      fork
         begin
            for (int k = 0; k < 16; k++) begin
               got = 1'b0;
               s_axi_araddr = 32'(k * 4);
               s_axi_arvalid = 1'b1;
               for (int c = 0; c < TMO && !got; c++) begin
                  @(negedge clk);
                  got = s_axi_arready;
                  nextCycle();
               end
               if (!got) checkOutput("toggle_ar_timeout", 0, 1);
            end
            s_axi_arvalid = 1'b0;
         end
         begin
            for (int c = 0; c < 120 && beats.size() < 16; c++) begin
               s_axi_rready = c[0];
               @(negedge clk);
               if (s_axi_rvalid && s_axi_rready) beats.push_back(s_axi_rdata);
               nextCycle();
            end
            s_axi_rready = 1'b0;
         end
      join
      repeat (3) nextCycle();
      checkOutput("toggle_no_extra_beat", s_axi_rvalid, 0);
      checkOutput("toggle_beat_count", beats.size(), 16);
      for (int k = 0; k < beats.size() && k < 16; k++) checkOutput("toggle_rdata", beats[k], modelMem[k]);
   endtask

   task automatic testBackpressure();
      logic [31:0] addrs [3];
      logic [31:0] datas [3];
      logic [31:0] rd;
      int awCnt;
      int wCnt;
      int bCnt;
      bit awHs;
      bit wHs;
      bit bHs;
      logic [1:0] resp;
      addrs = '{32'h40, 32'h44, 32'h44};
      for (int k = 0; k < 3; k++) datas[k] = $urandom;
      awCnt = 0;
      wCnt = 0;
      bCnt = 0;
      s_axi_wstrb = 4'hF;
      for (int c = 0; c < 80 && bCnt < 3; c++) begin
         if (c == 10) begin
            checkOutput("bp_aw_count", awCnt, 2);
            checkOutput("bp_w_count", wCnt, 2);
            checkOutput("bp_b_count_stalled", bCnt, 0);
            checkOutput("bp_bvalid_pending", s_axi_bvalid, 1);
            checkOutput("bp_awready_low", s_axi_awready, 0);
            checkOutput("bp_wready_low", s_axi_wready, 0);
            modelWrite(addrs[0], datas[0], 4'hF);
            axiRead(addrs[0], 0, rd);
            axiRead(addrs[1], 0, rd);
         end
         s_axi_bready = (c >= 10);
         s_axi_awvalid = (awCnt < 3);
         s_axi_awaddr = addrs[awCnt < 3 ? awCnt : 0];
         s_axi_wvalid = (wCnt < 3);
         s_axi_wdata = datas[wCnt < 3 ? wCnt : 0];
         @(negedge clk);
         awHs = s_axi_awvalid && s_axi_awready;
         wHs = s_axi_wvalid && s_axi_wready;
         bHs = s_axi_bvalid && s_axi_bready;
         resp = s_axi_bresp;
         nextCycle();
         if (awHs) awCnt++;
         if (wHs) wCnt++;
         if (bHs) begin
            checkOutput("bp_bresp", resp, 2'b00);
            bCnt++;
         end
      end
      s_axi_awvalid = 1'b0;
      s_axi_wvalid = 1'b0;
      s_axi_bready = 1'b0;
      checkOutput("bp_b_count_final", bCnt, 3);
      modelWrite(addrs[1], datas[1], 4'hF);
      modelWrite(addrs[2], datas[2], 4'hF);
      axiRead(addrs[0], 0, rd);
      axiRead(addrs[2], 0, rd);
      checkOutput("bp_last_write_wins", rd, datas[2]);
   endtask

   task automatic testRange();
      logic [31:0] rd;
      logic [31:0] before0;
      before0 = modelMem[0];
      axiWrite(32'h400, 32'h55, 4'hF, 0, 0, 0);
      axiRead(32'h400, 0, rd);
      axiRead(32'h000, 0, rd);
`ifdef AXIL_RAM_RANGE_CHK_EN
      checkOutput("range_word0_unchanged", rd, before0);
`else
      checkOutput("range_alias_word0", rd, 32'h55);
      checkOutput("range_word0_was", before0 == 32'h55 ? 0 : 1, before0 == 32'h55 ? 0 : 1);
`endif
   endtask

   task automatic testResetMidWrite();
      logic [31:0] rd;
      s_axi_awaddr = 32'h8;
      s_axi_awvalid = 1'b1;
      nextCycle();
      s_axi_awvalid = 1'b0;
      checkOutput("rst_aw_buffered", s_axi_awready, 0);
      rst_n = 1'b0;
      nextCycle();
      rst_n = 1'b1;
      checkOutput("rst_awready", s_axi_awready, 1);
      checkOutput("rst_wready", s_axi_wready, 1);
      s_axi_wdata = 32'hCAFEF00D;
      s_axi_wstrb = 4'hF;
      s_axi_wvalid = 1'b1;
      nextCycle();
      s_axi_wvalid = 1'b0;
      repeat (4) nextCycle();
      checkOutput("rst_no_bvalid", s_axi_bvalid, 0);
      axiRead(32'h8, 0, rd);
      rst_n = 1'b0;
      nextCycle();
      rst_n = 1'b1;
      checkOutput("rst_w_dropped", s_axi_wready, 1);
   endtask

   initial begin
      logic [31:0] rd;
      for (int i = 0; i < 256; i++) modelMem[i] = '0;
      rst_n = 1'b0;
      s_axi_awaddr = '0;
      s_axi_awvalid = 1'b0;
      s_axi_wdata = '0;
      s_axi_wstrb = '0;
      s_axi_wvalid = 1'b0;
      s_axi_bready = 1'b0;
      s_axi_araddr = '0;
      s_axi_arvalid = 1'b0;
      s_axi_rready = 1'b0;
      repeat (3) nextCycle();
      checkOutput("reset_awready", s_axi_awready, 1);
      checkOutput("reset_wready", s_axi_wready, 1);
      checkOutput("reset_arready", s_axi_arready, 1);
      checkOutput("reset_bvalid", s_axi_bvalid, 0);
      checkOutput("reset_bresp", s_axi_bresp, 2'b00);
      checkOutput("reset_rvalid", s_axi_rvalid, 0);
      checkOutput("reset_rresp", s_axi_rresp, 2'b00);
      checkOutput("reset_rdata", s_axi_rdata, 32'h0);
      rst_n = 1'b1;
      nextCycle();

      $display("[TB] same-cycle AW/W write");
      testSameCycleWrite();
      $display("[TB] W ahead of AW, partial strobes");
      testWriteDataFirst();
      for (int i = 0; i < 16; i++)
         axiWrite(32'(i * 4), $urandom, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), 0);
      $display("[TB] back-to-back reads");
      testBurstReads();
      testToggleReads();
      $display("[TB] B backpressure");
      testBackpressure();
      $display("[TB] address range handling");
      testRange();
      $display("[TB] reset between AW and W");
      testResetMidWrite();
      $display("[TB] randomized traffic");
      applyStimulus(80);
      axiRead(32'h10, 0, rd);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
